// File: rtl/sys_arr_ctrl.sv
// Sequencer for a weight-stationary systolic array: loads weight rows, streams
// skewed input vectors with per-row active strobes and flags bottom-row results.
module sys_arr_ctrl #(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int CNT_W = 8,
    parameter int RAW   = 1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    num_vecs,
    output logic                busy,
    output logic                done,
    output logic                w_rd_en,
    output logic [RAW-1:0]      w_rd_addr,
    output logic [ROWS-1:0]     wwrite,
    output logic                d_rd_en,
    output logic [CNT_W-1:0]    d_rd_addr,
    input  logic [8*ROWS-1:0]   d_in,
    output logic [8*ROWS-1:0]   row_data,
    output logic [ROWS-1:0]     act_row,
    output logic [COLS-1:0]     res_valid
);

    typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROWS + COLS);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, n_lat;

    logic             busy_d, done_d, w_rd_en_d, d_rd_en_d;
    logic [RAW-1:0]   w_rd_addr_d;
    logic [ROWS-1:0]  wwrite_d;
    logic [CNT_W-1:0] d_rd_addr_d;

    logic             rd_vld_p0;
    logic [COLS-1:0]  res_sr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            n_lat <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && start && !abort)
                n_lat <= num_vecs;
        end
    end

    // One counter serves every phase; it restarts at 0 on each state change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_vecs != '0) ? LOAD_W : DONE;
                    cnt_nxt   = '0;
                end
            end
            LOAD_W: begin
                if (cnt == LOAD_LAST) begin
                    state_nxt = FEED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            FEED: begin
                if (cnt == n_lat - ONE) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    // Outputs are decoded from the next state so they leave flops directly.
    always_comb begin
        busy_d      = (state_nxt == LOAD_W) || (state_nxt == FEED) || (state_nxt == DRAIN);
        done_d      = (state_nxt == DONE);
        w_rd_en_d   = (state_nxt == LOAD_W) && (cnt_nxt < LOAD_LAST);
        w_rd_addr_d = w_rd_en_d ? cnt_nxt[RAW-1:0] : '0;
        wwrite_d    = '0;
        for (int r = 0; r < ROWS; r++)
            wwrite_d[r] = (state_nxt == LOAD_W) && (cnt_nxt == CNT_W'(r + 1));
        d_rd_en_d   = (state_nxt == FEED);
        d_rd_addr_d = d_rd_en_d ? cnt_nxt : '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            w_rd_en   <= 1'b0;
            w_rd_addr <= '0;
            wwrite    <= '0;
            d_rd_en   <= 1'b0;
            d_rd_addr <= '0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            w_rd_en   <= w_rd_en_d;
            w_rd_addr <= w_rd_addr_d;
            wwrite    <= wwrite_d;
            d_rd_en   <= d_rd_en_d;
            d_rd_addr <= d_rd_addr_d;
        end
    end

    // --- p0: read data arrives from the buffer one cycle after d_rd_en ---
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            rd_vld_p0 <= 1'b0;
        else if (abort)
            rd_vld_p0 <= 1'b0;
        else
            rd_vld_p0 <= d_rd_en;
    end

    // --- p1..p(r+1): lane r captures d_in then shifts r extra stages ---
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        localparam int D = r + 1;
        logic [7:0]   dat_p [D];
        logic [D-1:0] act_p;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn)
                act_p <= '0;
            else if (abort)
                act_p <= '0;
            else
                act_p <= (act_p << 1) | D'(rd_vld_p0);
        end

        always_ff @(posedge clock) begin
            dat_p[0] <= d_in[8*r +: 8];
            for (int k = 1; k < D; k++)
                dat_p[k] <= dat_p[k-1];
        end

        assign act_row[r]          = act_p[D-1];
        assign row_data[8*r +: 8]  = act_p[D-1] ? dat_p[D-1] : 8'd0;
    end

    // --- result flags: one stage per PE hop along the bottom row ---
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            res_sr <= '0;
        else if (abort)
            res_sr <= '0;
        else
            res_sr <= (res_sr << 1) | COLS'(act_row[ROWS-1]);
    end

    assign res_valid = res_sr;

endmodule

// File: tb/tb_sys_arr_ctrl.sv
// Directed bench for sys_arr_ctrl: per-cycle output checks for nominal, zero-length,
// abort, ignored-start, asynchronous reset and maximum-length jobs.
module tb_sys_arr_ctrl;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int CNT_W = 4;
    localparam int RAW   = 1;
    localparam int F     = ROWS + 2;

    logic                clock = 1'b0;
    logic                resetn = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [CNT_W-1:0]    num_vecs = '0;
    logic                busy, done, w_rd_en, d_rd_en;
    logic [RAW-1:0]      w_rd_addr;
    logic [ROWS-1:0]     wwrite, act_row;
    logic [CNT_W-1:0]    d_rd_addr;
    logic [8*ROWS-1:0]   d_in = '0;
    logic [8*ROWS-1:0]   row_data;
    logic [COLS-1:0]     res_valid;

    int checks = 0;
    int errors = 0;

    // Hand-derived cycle table for ROWS=2, COLS=2, N=3, index = cycles after S.
    int tw_en [14] = '{0,1,1,0,0,0,0,0,0,0,0,0,0,0};
    int tw_a  [14] = '{0,0,1,0,0,0,0,0,0,0,0,0,0,0};
    int tww   [14] = '{0,0,1,2,0,0,0,0,0,0,0,0,0,0};
    int td_en [14] = '{0,0,0,0,1,1,1,0,0,0,0,0,0,0};
    int td_a  [14] = '{0,0,0,0,0,1,2,0,0,0,0,0,0,0};
    int tact  [14] = '{0,0,0,0,0,0,1,3,3,2,0,0,0,0};
    int trd   [14] = '{0,0,0,0,0,0,'h0010,'hA011,'hA112,'hA200,0,0,0,0};
    int trv   [14] = '{0,0,0,0,0,0,0,0,1,3,3,2,0,0};
    int tbusy [14] = '{0,1,1,1,1,1,1,1,1,1,1,1,0,0};
    int tdone [14] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,0};

    sys_arr_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .RAW(RAW)) dut (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort),
        .num_vecs(num_vecs), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .wwrite(wwrite),
        .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr), .d_in(d_in),
        .row_data(row_data), .act_row(act_row), .res_valid(res_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] lane_val(input int r, input int v);
        return 8'(16 + 144 * r + v);
    endfunction

    // Data buffer with one-cycle read latency.
    always @(posedge clock) begin
        if (d_rd_en)
            for (int r = 0; r < ROWS; r++)
                d_in[8*r +: 8] <= lane_val(r, int'(d_rd_addr));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string pfx, input int t,
                              input logic e_busy, input logic e_done,
                              input logic e_wen, input logic [RAW-1:0] e_wa,
                              input logic [ROWS-1:0] e_ww, input logic e_den,
                              input logic [CNT_W-1:0] e_da, input logic [8*ROWS-1:0] e_rd,
                              input logic [ROWS-1:0] e_act, input logic [COLS-1:0] e_rv);
        chk($sformatf("%s.busy@%0d", pfx, t),      32'(busy),      32'(e_busy));
        chk($sformatf("%s.done@%0d", pfx, t),      32'(done),      32'(e_done));
        chk($sformatf("%s.w_rd_en@%0d", pfx, t),   32'(w_rd_en),   32'(e_wen));
        chk($sformatf("%s.w_rd_addr@%0d", pfx, t), 32'(w_rd_addr), 32'(e_wa));
        chk($sformatf("%s.wwrite@%0d", pfx, t),    32'(wwrite),    32'(e_ww));
        chk($sformatf("%s.d_rd_en@%0d", pfx, t),   32'(d_rd_en),   32'(e_den));
        chk($sformatf("%s.d_rd_addr@%0d", pfx, t), 32'(d_rd_addr), 32'(e_da));
        chk($sformatf("%s.row_data@%0d", pfx, t),  32'(row_data),  32'(e_rd));
        chk($sformatf("%s.act_row@%0d", pfx, t),   32'(act_row),   32'(e_act));
        chk($sformatf("%s.res_valid@%0d", pfx, t), 32'(res_valid), 32'(e_rv));
    endtask

    // cut_t: cycle after S at which abort (or reset when cut_rst) is applied.
    task automatic job(input string pfx, input int n, input int len, input int cut_t,
                       input bit cut_rst, input int ign_a, input int ign_b, input bit use_tab);
        logic                e_busy, e_done, e_wen, e_den;
        logic [RAW-1:0]      e_wa;
        logic [ROWS-1:0]     e_ww, e_act;
        logic [CNT_W-1:0]    e_da;
        logic [8*ROWS-1:0]   e_rd;
        logic [COLS-1:0]     e_rv;
        int                  v;
        @(negedge clock);
        start    = 1'b1;
        num_vecs = CNT_W'(n);
        for (int t = 1; t <= len; t++) begin
            @(negedge clock);
            start = 1'b0;
            abort = 1'b0;
            if (cut_rst && t == cut_t + 2)
                resetn = 1'b1;
            e_busy = 0; e_done = 0; e_wen = 0; e_wa = '0; e_ww = '0;
            e_den = 0; e_da = '0; e_rd = '0; e_act = '0; e_rv = '0;
            if (use_tab) begin
                e_busy = tbusy[t] != 0; e_done = tdone[t] != 0;
                e_wen  = tw_en[t] != 0; e_wa   = RAW'(tw_a[t]);
                e_ww   = ROWS'(tww[t]); e_den  = td_en[t] != 0;
                e_da   = CNT_W'(td_a[t]); e_rd = (8*ROWS)'(trd[t]);
                e_act  = ROWS'(tact[t]); e_rv  = COLS'(trv[t]);
            end else if (cut_t > 0 && t > cut_t) begin
                e_busy = 0;
            end else if (n == 0) begin
                e_done = (t == 1);
            end else begin
                e_wen = (t >= 1 && t <= ROWS);
                if (e_wen) e_wa = RAW'(t - 1);
                for (int k = 0; k < ROWS; k++) e_ww[k] = (t == 2 + k);
                e_den = (t >= F && t < F + n);
                if (e_den) e_da = CNT_W'(t - F);
                for (int r = 0; r < ROWS; r++) begin
                    v = t - F - 2 - r;
                    e_act[r] = (v >= 0 && v < n);
                    if (e_act[r]) e_rd[8*r +: 8] = lane_val(r, v);
                end
                for (int c = 0; c < COLS; c++) begin
                    v = t - F - ROWS - 2 - c;
                    e_rv[c] = (v >= 0 && v < n);
                end
                e_busy = (t >= 1 && t <= F + n + ROWS + COLS);
                e_done = (t == F + n + ROWS + COLS + 1);
            end
            check_outs(pfx, t, e_busy, e_done, e_wen, e_wa, e_ww, e_den, e_da, e_rd, e_act, e_rv);
            if (t == cut_t) begin
                if (cut_rst) begin
                    resetn = 1'b0;
                    #1;
                    check_outs({pfx, "_async"}, t, 0, 0, 0, '0, '0, 0, '0, '0, '0, '0);
                end else begin
                    abort = 1'b1;
                end
            end
            if (t == ign_a || t == ign_b) begin
                start    = 1'b1;
                num_vecs = CNT_W'(1);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_outs("reset", 0, 0, 0, 0, '0, '0, 0, '0, '0, '0, '0);
        resetn = 1'b1;
        @(negedge clock);
        job("nominal",     3,  13,          0, 0, 0, 0,  1);
        job("zero",        0,  4,           0, 0, 0, 0,  0);
        job("abort",       5,  7,           5, 0, 0, 0,  0);
        job("after_abort", 5,  F + 5 + 7,   0, 0, 0, 0,  0);
        job("ignore",      3,  16,          0, 0, 5, 12, 0);
        job("rst",         3,  10,          5, 1, 0, 0,  0);
        job("clean",       3,  13,          0, 0, 0, 0,  0);
        job("max",         15, F + 15 + 7,  0, 0, 0, 0,  0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
